// File: rtl/sprite_motion_ctrl_if.sv
// Bundles the vsync/button inputs and sprite state outputs of sprite_motion_ctrl.
interface sprite_motion_ctrl_if;
  logic       vsync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] img_x;
  logic [9:0] img_y;
  logic [2:0] frame_idx;
  logic       is_moving;
  logic       face_left;
  logic [1:0] state;
  logic       frame_tick;

  // Drives buttons and vsync, observes sprite state.
  modport master (
    output vsync, btn_left, btn_right, btn_jump,
    input  img_x, img_y, frame_idx, is_moving, face_left, state, frame_tick
  );

  // The motion controller itself.
  modport slave (
    input  vsync, btn_left, btn_right, btn_jump,
    output img_x, img_y, frame_idx, is_moving, face_left, state, frame_tick
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion/animation controller: walking, jump/gravity FSM and
// frame-index sequencer, all advanced once per synchronized vsync rising edge.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump per airtime).
module sprite_motion_ctrl #(
  parameter int unsigned X_MAX       = 608,
  parameter int unsigned FLOOR_Y     = 416,
  parameter int unsigned WALK_STEP   = 2,
  parameter int unsigned JUMP_V0     = 12,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned VY_MAX      = 15,
  parameter int unsigned ANIM_DIV    = 6,
  parameter int unsigned IDLE_FRAMES = 4,
  parameter int unsigned WALK_FRAMES = 6
) (
  input logic               clk,
  input logic               rst,
  sprite_motion_ctrl_if.slave bus
);
  localparam int unsigned DivW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [10:0] XMax   = 11'(X_MAX);
  localparam logic [10:0] FloorY = 11'(FLOOR_Y);
  localparam logic [10:0] Step   = 11'(WALK_STEP);
  localparam logic [4:0]  JumpV0 = 5'(JUMP_V0);
  localparam logic [4:0]  Grav   = 5'(GRAVITY);
  localparam logic [5:0]  VyMax  = 6'(VY_MAX);

  typedef enum logic [1:0] {StGround = 2'd0, StRise = 2'd1, StFall = 2'd2} st_e;

  logic            vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [4:0]      vy_q, vy_d;
  logic [2:0]      frame_q, frame_d;
  logic [DivW-1:0] div_q, div_d;
  logic            moving_q, moving_d, face_q, face_d, armed_q, armed_d;
  st_e             state_q, state_d;
  logic            air_ok;

`ifdef DOUBLE_JUMP_EN
  logic credit_q, credit_d;
  assign air_ok = credit_q;
`else
  assign air_ok = 1'b0;
`endif

  // vsync synchronizer and edge detect; flops reset high so a vsync already
  // high at reset release must drop and rise again before a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_q    <= 1'b1;
      vs_sync_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vs_meta_q    <= bus.vsync;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      frame_tick_q <= vs_sync_q & ~vs_prev_q;
    end
  end

  // Sprite state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= FloorY[9:0];
      vy_q     <= '0;
      frame_q  <= '0;
      div_q    <= '0;
      moving_q <= 1'b0;
      face_q   <= 1'b0;
      armed_q  <= 1'b0;
      state_q  <= StGround;
`ifdef DOUBLE_JUMP_EN
      credit_q <= 1'b1;
`endif
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      frame_q  <= frame_d;
      div_q    <= div_d;
      moving_q <= moving_d;
      face_q   <= face_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
`ifdef DOUBLE_JUMP_EN
      credit_q <= credit_d;
`endif
    end
  end

  logic        walk, takeoff, air_jump;
  logic [10:0] x_ext, y_ext, x_inc;
  logic [5:0]  vy_sum;
  logic [4:0]  nvy;
  logic [2:0]  strip_last;

  // Next-state for movement, jump FSM and animation; only a tick advances it.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    vy_d     = vy_q;
    frame_d  = frame_q;
    div_d    = div_q;
    moving_d = moving_q;
    face_d   = face_q;
    armed_d  = armed_q;
    state_d  = state_q;
`ifdef DOUBLE_JUMP_EN
    credit_d = credit_q;
`endif
    walk       = bus.btn_left ^ bus.btn_right;
    takeoff    = 1'b0;
    air_jump   = bus.btn_jump & armed_q & air_ok;
    x_ext      = {1'b0, x_q};
    y_ext      = {1'b0, y_q};
    x_inc      = x_ext + Step;
    vy_sum     = {1'b0, vy_q} + {1'b0, Grav};
    nvy        = (vy_sum > VyMax) ? VyMax[4:0] : vy_sum[4:0];
    strip_last = moving_q ? 3'(WALK_FRAMES - 1) : 3'(IDLE_FRAMES - 1);

    if (frame_tick_q) begin
      moving_d = walk;
      if (walk) begin
        face_d = bus.btn_left;
        if (bus.btn_left) x_d = (x_ext < Step) ? 10'd0 : 10'(x_ext - Step);
        else              x_d = (x_inc > XMax) ? XMax[9:0] : x_inc[9:0];
      end

      // A change of strip restarts it; otherwise step every ANIM_DIV ticks.
      if (walk != moving_q) begin
        frame_d = '0;
        div_d   = '0;
      end else if (div_q == DivW'(ANIM_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == strip_last) ? 3'd0 : frame_q + 3'd1;
      end else begin
        div_d = div_q + 1'b1;
      end

      unique case (state_q)
        StGround: begin
          if (bus.btn_jump && armed_q) begin
            takeoff = 1'b1;
            vy_d    = JumpV0;
            state_d = StRise;
          end
        end
        StRise: begin
          if (air_jump) begin
            takeoff = 1'b1;
            vy_d    = JumpV0;
          end else if ({6'd0, vy_q} > y_ext) begin
            y_d     = '0;
            vy_d    = '0;
            state_d = StFall;
          end else begin
            y_d = 10'(y_ext - {6'd0, vy_q});
            if (vy_q <= Grav) begin
              vy_d    = '0;
              state_d = StFall;
            end else begin
              vy_d = vy_q - Grav;
            end
          end
        end
        StFall: begin
          if (air_jump) begin
            takeoff = 1'b1;
            vy_d    = JumpV0;
            state_d = StRise;
          end else if (y_ext + {6'd0, nvy} >= FloorY) begin
            y_d     = FloorY[9:0];
            vy_d    = '0;
            state_d = StGround;
`ifdef DOUBLE_JUMP_EN
            credit_d = 1'b1;
`endif
          end else begin
            y_d  = 10'(y_ext + {6'd0, nvy});
            vy_d = nvy;
          end
        end
        default: state_d = StGround;
      endcase

`ifdef DOUBLE_JUMP_EN
      if (air_jump && state_q != StGround) credit_d = 1'b0;
`endif
      // Release re-arms; takeoff consumes the arm so a held button cannot repeat.
      if (!bus.btn_jump) armed_d = 1'b1;
      else if (takeoff)  armed_d = 1'b0;
    end
  end

  assign bus.img_x      = x_q;
  assign bus.img_y      = y_q;
  assign bus.frame_idx  = frame_q;
  assign bus.is_moving  = moving_q;
  assign bus.face_left  = face_q;
  assign bus.state      = state_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: a frame-level reference model pushes
// expected sprite state per vsync; a monitor pops and compares after each tick.
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_motion_ctrl_if bus();

  sprite_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int x, y, fidx, mov, face, st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (frame-level).
  int m_x, m_y, m_vy, m_st, m_frame, m_div, m_mov, m_face, m_armed, m_credit;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 416; m_vy = 0; m_st = 0; m_frame = 0; m_div = 0;
    m_mov = 0; m_face = 0; m_armed = 0; m_credit = 1;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j);
    int  mv, nvy;
    bit  took, air_jump;
    exp_t e;
    mv = (l != r) ? 1 : 0;
    if (mv == 1) begin
      if (l) m_x = (m_x < 2) ? 0 : m_x - 2;
      else   m_x = (m_x + 2 > 608) ? 608 : m_x + 2;
      m_face = l ? 1 : 0;
    end
    if (mv != m_mov) begin
      m_frame = 0; m_div = 0;
    end else if (m_div == 5) begin
      m_div = 0;
      m_frame = (m_frame + 1) % (m_mov ? 6 : 4);
    end else begin
      m_div++;
    end
    m_mov = mv;
    took = 0;
`ifdef DOUBLE_JUMP_EN
    air_jump = j && (m_armed == 1) && (m_credit == 1) && (m_st != 0);
`else
    air_jump = 0;
`endif
    if (air_jump) begin
      m_vy = 12; m_st = 1; m_credit = 0; took = 1;
    end else if (m_st == 0) begin
      if (j && m_armed == 1) begin m_st = 1; m_vy = 12; took = 1; end
    end else if (m_st == 1) begin
      if (m_vy > m_y) begin m_y = 0; m_vy = 0; m_st = 2; end
      else begin
        m_y -= m_vy;
        if (m_vy <= 1) begin m_vy = 0; m_st = 2; end
        else m_vy -= 1;
      end
    end else begin
      nvy = (m_vy + 1 > 15) ? 15 : m_vy + 1;
      if (m_y + nvy >= 416) begin m_y = 416; m_vy = 0; m_st = 0; m_credit = 1; end
      else begin m_y += nvy; m_vy = nvy; end
    end
    if (!j) m_armed = 1;
    else if (took) m_armed = 0;
    e.x = m_x; e.y = m_y; e.fidx = m_frame; e.mov = m_mov; e.face = m_face; e.st = m_st;
    exp_q.push_back(e);
  endtask

  // One video frame: hold buttons, pulse vsync, confirm tick latency.
  task automatic frame(input bit l, input bit r, input bit j);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.btn_left = l; bus.btn_right = r; bus.btn_jump = j;
    bus.vsync = 1'b1;
    model_step(l, r, j);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin lat = i; break; end
    end
    chk("tick_latency", lat, 3);
    repeat (2) @(negedge clk);
    bus.vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frames(input int n, input bit l, input bit r, input bit j);
    for (int i = 0; i < n; i++) frame(l, r, j);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, int'(bus.img_x), 0);
    chk({tag, "_y"}, int'(bus.img_y), 416);
    chk({tag, "_fidx"}, int'(bus.frame_idx), 0);
    chk({tag, "_mov"}, int'(bus.is_moving), 0);
    chk({tag, "_face"}, int'(bus.face_left), 0);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_tick"}, int'(bus.frame_tick), 0);
  endtask

  // Monitor: after every tick the outputs settle on the edge ending it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.frame_tick) begin
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("img_x", int'(bus.img_x), e.x);
          chk("img_y", int'(bus.img_y), e.y);
          chk("frame_idx", int'(bus.frame_idx), e.fidx);
          chk("is_moving", int'(bus.is_moving), e.mov);
          chk("face_left", int'(bus.face_left), e.face);
          chk("state", int'(bus.state), e.st);
        end
      end
    end
  end

  initial begin
    int ticks;
    bit l, r, j;
    bus.vsync = 1'b1; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    // vsync already high at release must not tick.
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.frame_tick) ticks++;
    end
    chk("no_tick_at_release", ticks, 0);
    bus.vsync = 1'b0;
    repeat (4) @(negedge clk);

    frames(6, 0, 0, 0);
    chk("idle_frame_after_6", int'(bus.frame_idx), 1);
    frames(2, 0, 0, 0);

    frames(10, 0, 1, 0);
    chk("walk_right_x", int'(bus.img_x), 20);
    frames(12, 1, 0, 0);
    chk("walk_left_x", int'(bus.img_x), 0);
    chk("walk_left_face", int'(bus.face_left), 1);

    frame(0, 0, 0);
    frame(0, 0, 1);
    chk("takeoff_state", int'(bus.state), 1);
    frames(12, 0, 0, 1);
    chk("apex_y", int'(bus.img_y), 338);
    chk("apex_state", int'(bus.state), 2);
    frames(12, 0, 0, 1);
    chk("land_y", int'(bus.img_y), 416);
    frames(5, 0, 0, 1);
    chk("held_no_rejump", int'(bus.state), 0);

    frames(37, 0, 1, 0);
    frame(0, 0, 0);
    chk("release_fidx", int'(bus.frame_idx), 0);
    frames(20, 0, 0, 0);

    frame(0, 0, 0);
    frame(0, 0, 1);
    frames(12, 0, 0, 1);
    frame(0, 0, 0);
    frame(0, 0, 1);
`ifdef DOUBLE_JUMP_EN
    chk("air_jump_state", int'(bus.state), 1);
`else
    chk("air_jump_state", int'(bus.state), 2);
`endif
    frame(0, 0, 0);
    frame(0, 0, 1);
    frames(45, 0, 0, 0);
    chk("dj_landed", int'(bus.state), 0);

    frame(0, 0, 0);
    frame(0, 0, 1);
    frames(2, 0, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    frames(5, 0, 0, 1);
    chk("no_jump_after_reset", int'(bus.state), 0);

    frames(310, 0, 1, 0);
    chk("right_wall_x", int'(bus.img_x), 608);
    frames(3, 1, 1, 0);

    for (int i = 0; i < 300; i++) begin
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 3) != 0);
      frame(l, r, j);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
